// File: rtl/bnn_conv_stream_if.sv
// Stream, weight-load and frame-control signals of the binary-weight KxK convolution engine.
// The engine uses the slave view; whoever feeds it columns and weights uses the master view.
interface bnn_conv_stream_if #(
    parameter int K     = 5,
    parameter int DW    = 8,
    parameter int OUT_W = 16,
    parameter int CW    = 10
);
    logic                    start;
    logic [CW-1:0]           cfg_width;
    logic [CW-1:0]           cfg_rows;
    logic                    cfg_bin;
    logic                    w_valid;
    logic                    w_bit;
    logic                    w_ready;
    logic                    in_valid;
    logic [K*DW-1:0]         in_col;
    logic                    in_ready;
    logic                    out_valid;
    logic signed [OUT_W-1:0] dout;
    logic                    out_last;
    logic                    busy;
    logic                    done;

    modport slave (
        input  start, cfg_width, cfg_rows, cfg_bin, w_valid, w_bit, in_valid, in_col,
        output w_ready, in_ready, out_valid, dout, out_last, busy, done
    );

    modport master (
        output start, cfg_width, cfg_rows, cfg_bin, w_valid, w_bit, in_valid, in_col,
        input  w_ready, in_ready, out_valid, dout, out_last, busy, done
    );
endinterface

// File: rtl/bnn_conv_stream.sv
// Binary-weight KxK streaming convolution: sliding column window, registered adder tree,
// saturating or sign-binarised output, and a double-buffered serially loaded weight bank.
module bnn_conv_stream #(
    parameter int K     = 5,
    parameter int DW    = 8,
    parameter int OUT_W = 16,
    parameter int CW    = 10
) (
    input  logic             clk,
    input  logic             rstn,
    bnn_conv_stream_if.slave bus
);
    localparam int N       = K * K;
    localparam int LV      = $clog2(N);
    localparam int SW      = DW + LV + 1;
    localparam int LAT     = 2 + LV;
    localparam int IW      = (N > 1) ? $clog2(N) : 1;
    localparam int DCW     = $clog2(LAT + 1);
    localparam int SAT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int SAT_MIN = -(1 << (OUT_W - 1));

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    // Number of live nodes at a given adder-tree level; odd leftovers ride through.
    function automatic int levelCount(input int lvl);
        int n;
        n = N;
        for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
        return n;
    endfunction

    state_e           state_q, state_d;
    logic [CW-1:0]    col_q, col_d, row_q, row_d;
    logic [CW-1:0]    width_q, width_d, rows_q, rows_d;
    logic             bin_q, bin_d, done_q, done_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic             frameLast;

    logic [N-1:0]     shadow_q, active_q;
    logic             shadowFull_q;
    logic [IW-1:0]    wIdx_q;

    logic [K*DW-1:0]  win_q [K];
    logic             winValid_q, winLast_q;
    logic signed [SW-1:0] tree_q [LV+1][N];
    logic [LV:0]      pipeValid_q, pipeLast_q;
    logic                    outValid_q, outLast_q;
    logic signed [OUT_W-1:0] dout_q, result;
    logic signed [SW-1:0]    sum;

    logic accept, wBeat, swap;

    assign accept = bus.in_valid && (state_q == RUN);
    assign wBeat  = bus.w_valid && !shadowFull_q;
    assign swap   = bus.start && (state_q == IDLE) && shadowFull_q;
    assign sum    = tree_q[LV][0];

    assign bus.w_ready   = ~shadowFull_q;
    assign bus.in_ready  = (state_q == RUN);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.out_valid = outValid_q;
    assign bus.out_last  = outLast_q;
    assign bus.dout      = dout_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            width_q <= '0;
            rows_q  <= '0;
            bin_q   <= 1'b0;
            done_q  <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            width_q <= width_d;
            rows_q  <= rows_d;
            bin_q   <= bin_d;
            done_q  <= done_d;
            drain_q <= drain_d;
        end
    end

    // Empty geometry skips RUN; DRAIN always lasts long enough for the tree to empty.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        width_d   = width_q;
        rows_d    = rows_q;
        bin_d     = bin_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        frameLast = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    width_d = bus.cfg_width;
                    rows_d  = bus.cfg_rows;
                    bin_d   = bus.cfg_bin;
                    col_d   = '0;
                    row_d   = '0;
                    drain_d = '0;
                    state_d = (bus.cfg_width == '0 || bus.cfg_rows == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    if (col_q == width_q - 1'b1) begin
                        col_d = '0;
                        if (row_q == rows_q - 1'b1) begin
                            frameLast = 1'b1;
                            drain_d   = '0;
                            state_d   = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == DCW'(LAT)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full shadow bank blocks further bits until a start in IDLE moves it to the active bank.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            shadow_q     <= '0;
            active_q     <= '0;
            shadowFull_q <= 1'b0;
            wIdx_q       <= '0;
        end else begin
            if (wBeat) begin
                shadow_q[wIdx_q] <= bus.w_bit;
                if (wIdx_q == IW'(N - 1)) begin
                    shadowFull_q <= 1'b1;
                    wIdx_q       <= '0;
                end else begin
                    wIdx_q <= wIdx_q + 1'b1;
                end
            end
            if (swap) begin
                active_q     <= shadow_q;
                shadowFull_q <= 1'b0;
            end
        end
    end

    always_comb begin
        if (bin_q)
            result = sum[SW-1] ? '1 : OUT_W'(1);
        else if (int'(sum) > SAT_MAX)
            result = OUT_W'(SAT_MAX);
        else if (int'(sum) < SAT_MIN)
            result = OUT_W'(SAT_MIN);
        else
            result = OUT_W'(sum);
    end

    // win_q[0] is the oldest column; validity requires K columns of the current row.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int c = 0; c < K; c++) win_q[c] <= '0;
            for (int l = 0; l <= LV; l++)
                for (int j = 0; j < N; j++) tree_q[l][j] <= '0;
            winValid_q  <= 1'b0;
            winLast_q   <= 1'b0;
            pipeValid_q <= '0;
            pipeLast_q  <= '0;
            outValid_q  <= 1'b0;
            outLast_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            if (accept) begin
                for (int c = 0; c < K - 1; c++) win_q[c] <= win_q[c+1];
                win_q[K-1] <= bus.in_col;
            end
            winValid_q <= accept && (col_q >= CW'(K - 1));
            winLast_q  <= frameLast && (col_q >= CW'(K - 1));

            for (int r = 0; r < K; r++)
                for (int c = 0; c < K; c++)
                    tree_q[0][r*K+c] <= active_q[r*K+c] ?  SW'($signed(win_q[c][r*DW +: DW]))
                                                        : -SW'($signed(win_q[c][r*DW +: DW]));

            for (int l = 1; l <= LV; l++)
                for (int j = 0; j < N; j++)
                    if (2 * j + 1 < levelCount(l - 1))
                        tree_q[l][j] <= tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
                    else if (2 * j < levelCount(l - 1))
                        tree_q[l][j] <= tree_q[l-1][2*j];
                    else
                        tree_q[l][j] <= '0;

            pipeValid_q <= {pipeValid_q[LV-1:0], winValid_q};
            pipeLast_q  <= {pipeLast_q[LV-1:0], winLast_q};
            outValid_q  <= pipeValid_q[LV];
            outLast_q   <= pipeValid_q[LV] & pipeLast_q[LV];
            if (pipeValid_q[LV]) dout_q <= result;
        end
    end
endmodule

// File: tb/tb_bnn_conv_stream.sv
// Directed bench for bnn_conv_stream: a 16-bit-output and an 8-bit-output instance
// share one stimulus stream, so saturation is observed alongside the normal result.
module tb_bnn_conv_stream;
    localparam int K       = 5;
    localparam int DW      = 8;
    localparam int CW      = 10;
    localparam int LAT_EXP = 7;

    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    longint outA[$];
    longint outS[$];
    int     outCyc[$];
    int     expCyc[$];
    bit     outLastQ[$];
    int     doneCnt = 0;
    int     doneCyc = 0;
    int     lastAcc = 0;

    bnn_conv_stream_if #(.K(K), .DW(DW), .OUT_W(16), .CW(CW)) ifA ();
    bnn_conv_stream_if #(.K(K), .DW(DW), .OUT_W(8),  .CW(CW)) ifS ();

    assign ifS.start     = ifA.start;
    assign ifS.cfg_width = ifA.cfg_width;
    assign ifS.cfg_rows  = ifA.cfg_rows;
    assign ifS.cfg_bin   = ifA.cfg_bin;
    assign ifS.w_valid   = ifA.w_valid;
    assign ifS.w_bit     = ifA.w_bit;
    assign ifS.in_valid  = ifA.in_valid;
    assign ifS.in_col    = ifA.in_col;

    bnn_conv_stream #(.K(K), .DW(DW), .OUT_W(16), .CW(CW)) dutA (
        .clk (clk),
        .rstn(rstn),
        .bus (ifA.slave)
    );

    bnn_conv_stream #(.K(K), .DW(DW), .OUT_W(8), .CW(CW)) dutS (
        .clk (clk),
        .rstn(rstn),
        .bus (ifS.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Outputs are sampled on the falling edge, tagged with the rising-edge count that produced them.
    always @(negedge clk) begin
        if (ifA.out_valid) begin
            outA.push_back(longint'($signed(ifA.dout)));
            outCyc.push_back(cyc);
            outLastQ.push_back(ifA.out_last);
        end
        if (ifS.out_valid) outS.push_back(longint'($signed(ifS.dout)));
        if (ifA.done) begin
            doneCnt++;
            doneCyc = cyc;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadWeights(input bit v);
        int beats;
        beats = 0;
        ifA.w_bit   = v;
        ifA.w_valid = 1'b1;
        for (int t = 0; t < 100 && beats < K * K; t++) begin
            if (ifA.w_ready) beats++;
            tick();
        end
        ifA.w_valid = 1'b0;
        checkOutput("wLoadBeats", beats, K * K);
    endtask

    task automatic startFrame(input int width, input int rows, input bit bin);
        outA.delete();
        outS.delete();
        outCyc.delete();
        outLastQ.delete();
        expCyc.delete();
        doneCnt       = 0;
        doneCyc       = 0;
        ifA.cfg_width = CW'(width);
        ifA.cfg_rows  = CW'(rows);
        ifA.cfg_bin   = bin;
        ifA.start     = 1'b1;
        tick();
        lastAcc   = cyc;
        ifA.start = 1'b0;
    endtask

    task automatic applyStimulus(input int pix, input int width, input int rows, input bit gap);
        logic [DW-1:0] p;
        p = DW'(pix);
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < width; c++) begin
                ifA.in_valid = 1'b1;
                ifA.in_col   = {K{p}};
                tick();
                lastAcc = cyc;
                if (c >= K - 1) expCyc.push_back(cyc);
                if (gap) begin
                    ifA.in_valid = 1'b0;
                    tick();
                end
            end
        end
        ifA.in_valid = 1'b0;
    endtask

    task automatic waitFrameEnd();
        for (int i = 0; i < 60 && doneCnt == 0; i++) tick();
        tick(2);
        checkOutput("doneSeen", doneCnt, 1);
    endtask

    task automatic checkFrame(input int n, input longint vA, input longint vS);
        checkOutput("outCount", outA.size(), n);
        checkOutput("outCountSat", outS.size(), n);
        for (int i = 0; i < outA.size() && i < n; i++) begin
            checkOutput("dout", outA[i], vA);
            if (i < outS.size()) checkOutput("doutSat", outS[i], vS);
            if (i < expCyc.size()) checkOutput("latency", outCyc[i] - expCyc[i], LAT_EXP);
            checkOutput("outLast", outLastQ[i], (i == n - 1) ? 1 : 0);
        end
        checkOutput("doneAfterLastAccept", doneCyc - lastAcc, LAT_EXP + 1);
    endtask

    initial begin
        rstn          = 1'b1;
        ifA.start     = 1'b0;
        ifA.cfg_width = '0;
        ifA.cfg_rows  = '0;
        ifA.cfg_bin   = 1'b0;
        ifA.w_valid   = 1'b0;
        ifA.w_bit     = 1'b0;
        ifA.in_valid  = 1'b0;
        ifA.in_col    = '0;
        tick(3);
        checkOutput("rstWReady",   ifA.w_ready,   1);
        checkOutput("rstInReady",  ifA.in_ready,  0);
        checkOutput("rstOutValid", ifA.out_valid, 0);
        checkOutput("rstDout",     ifA.dout,      0);
        checkOutput("rstOutLast",  ifA.out_last,  0);
        checkOutput("rstBusy",     ifA.busy,      0);
        checkOutput("rstDone",     ifA.done,      0);
        rstn = 1'b0;
        tick(2);

        $display("[TB] all-ones kernel, pixels 2");
        loadWeights(1'b1);
        startFrame(8, 1, 1'b0);
        checkOutput("busyAfterStart", ifA.busy, 1);
        checkOutput("wReadyAfterSwap", ifA.w_ready, 1);
        applyStimulus(2, 8, 1, 1'b0);
        waitFrameEnd();
        checkFrame(4, 50, 50);

        $display("[TB] all-zeros kernel, normal and binarised");
        loadWeights(1'b0);
        startFrame(8, 1, 1'b0);
        applyStimulus(2, 8, 1, 1'b0);
        waitFrameEnd();
        checkFrame(4, -50, -50);
        startFrame(8, 1, 1'b1);
        applyStimulus(2, 8, 1, 1'b0);
        waitFrameEnd();
        checkFrame(4, -1, -1);
        startFrame(8, 1, 1'b1);
        applyStimulus(0, 8, 1, 1'b0);
        waitFrameEnd();
        checkFrame(4, 1, 1);

        $display("[TB] saturation on the 8-bit instance");
        loadWeights(1'b1);
        startFrame(8, 1, 1'b0);
        applyStimulus(127, 8, 1, 1'b0);
        waitFrameEnd();
        checkFrame(4, 3175, 127);
        startFrame(8, 1, 1'b0);
        applyStimulus(-128, 8, 1, 1'b0);
        waitFrameEnd();
        checkFrame(4, -3200, -128);

        $display("[TB] double buffer: next kernel loads during the frame");
        startFrame(8, 1, 1'b0);
        fork
            loadWeights(1'b0);
            applyStimulus(2, 8, 1, 1'b0);
        join
        waitFrameEnd();
        checkFrame(4, 50, 50);
        checkOutput("wReadyShadowFull", ifA.w_ready, 0);
        startFrame(8, 1, 1'b0);
        checkOutput("wReadyAfterSwap2", ifA.w_ready, 1);
        applyStimulus(2, 8, 1, 1'b0);
        waitFrameEnd();
        checkFrame(4, -50, -50);

        $display("[TB] bubbles every other cycle, width 6, rows 2");
        startFrame(6, 2, 1'b0);
        applyStimulus(2, 6, 2, 1'b1);
        waitFrameEnd();
        checkFrame(4, -50, -50);

        $display("[TB] empty and narrow frames");
        startFrame(0, 3, 1'b0);
        waitFrameEnd();
        checkFrame(0, 0, 0);
        startFrame(3, 1, 1'b0);
        applyStimulus(2, 3, 1, 1'b0);
        waitFrameEnd();
        checkFrame(0, 0, 0);

        $display("[TB] reset in the middle of a frame");
        loadWeights(1'b1);
        startFrame(8, 1, 1'b0);
        ifA.in_valid = 1'b1;
        ifA.in_col   = {K{8'sd2}};
        tick(5);
        rstn         = 1'b1;
        ifA.in_valid = 1'b0;
        tick(2);
        checkOutput("midRstOutValid", ifA.out_valid, 0);
        checkOutput("midRstDout",     ifA.dout,      0);
        checkOutput("midRstOutLast",  ifA.out_last,  0);
        checkOutput("midRstBusy",     ifA.busy,      0);
        checkOutput("midRstWReady",   ifA.w_ready,   1);
        rstn = 1'b0;
        outA.delete();
        doneCnt = 0;
        tick(15);
        checkOutput("midRstNoOutputs", outA.size(), 0);
        checkOutput("midRstNoDone",    doneCnt,     0);
        startFrame(5, 1, 1'b0);
        applyStimulus(1, 5, 1, 1'b0);
        waitFrameEnd();
        checkFrame(1, -25, -25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bnn_conv_stream.md
Name: bnn_conv_stream

Overview:
- Parametrised binary-weight KxK convolution engine and the successor of the fixed 5x5 conv block.
- Consumes one K-pixel column per accepted beat from the sliding-window line buffer. Weights are +1/-1 (1 bit) and are loaded serially into a double-buffered bank, so the next kernel can load while the current frame runs.
- Supports arbitrary frame width and row count, input back-pressure via bubbles, a saturating output and an optional sign-binarised output mode.

Parameters:
- K, 5, kernel size (KxK window, stride 1)
- DW, 8, signed input pixel width
- OUT_W, 16, signed output width, saturating
- CW, 10, width of the frame geometry config fields

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous reset, active-high
- start  in  1  frame start pulse, sampled only in IDLE
- cfg_width  in  CW  columns per row pass, latched on start
- cfg_rows  in  CW  row passes per frame, latched on start
- cfg_bin  in  1  1 = binarised output (+1/-1), latched on start
- w_valid  in  1  weight bit valid
- w_bit  in  1  weight bit (1 = +x, 0 = -x)
- w_ready  out  1  shadow weight bank can accept a bit
- in_valid  in  1  input column valid
- in_col  in  K*DW  column; row r (0 = top) at bits [(r+1)*DW-1 : r*DW]
- in_ready  out  1  high in RUN
- out_valid  out  1  dout valid
- dout  out  OUT_W  convolution result, signed
- out_last  out  1  with the final out_valid of the frame
- busy  out  1  state is not IDLE
- done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset values: w_ready=1, in_ready=0, out_valid=0, dout=0, out_last=0, busy=0, done=0. Both weight banks are cleared to 0, shadow_full=0, all counters are 0 and the state is IDLE. Reset mid-frame aborts the frame with no done pulse.
- Weight loading:
  - A beat is w_valid&w_ready. It writes shadow[idx] with idx 0..K*K-1 in raster order, idx = r*K + c, c=0 = oldest column.
  - On idx = K*K-1 the block sets shadow_full=1, clears w_ready and resets idx to 0.
  - Loading is allowed in any state.
- Weight swap:
  - On start in IDLE with shadow_full=1 (registered value), the active bank takes the shadow contents, shadow_full clears and w_ready rises.
  - If shadow_full=0, the active bank is kept and reused.
  - A last bit arriving in the same cycle as start is not swapped; it takes effect at the next start.
- FSM states:
  - IDLE -> RUN on start. Latch the cfg fields, clear col/row. If cfg_width=0 or cfg_rows=0, go to DRAIN directly.
  - RUN: in_ready=1. Each accepted column shifts the K-column window; col increments and wraps at cfg_width-1, where row increments. Accepting the last column of the last row moves to DRAIN. in_valid low inserts a bubble; the pipeline keeps advancing without stalling.
  - DRAIN: wait LAT cycles so the pipeline empties, pulse done, return to IDLE.
- start outside IDLE is ignored. in_valid outside RUN is ignored.
- Window validity: a window is valid when the accepted column has col >= K-1 within the current row. The window never spans rows. cfg_width < K produces no outputs but still produces done.
- Arithmetic:
  - Products are +/-x with x sign-extended to SW = DW + clog2(K*K) + 1 bits.
  - The adder tree is registered per level: clog2(K*K) levels, with odd leftovers passed through.
  - Final stage, normal mode: saturate to OUT_W (clamp to +/-(2^(OUT_W-1)) limits).
  - Final stage, cfg_bin=1: dout = +1 if sum >= 0, else -1.
- Latency: LAT = 2 + clog2(K*K), measured from the accept cycle of the completing column to out_valid. For K=5 this is 7 cycles.
  - out_valid comes from a valid bit that travels alongside the data.
  - out_last marks the window of the last column of the last row.
  - done asserts the cycle after out_last, or LAT+1 cycles after entering DRAIN when there are no outputs.

Test Plan:
- Load 25 ones; start with width=8, rows=1; send columns of all pixels=2 -> 4 outputs of 50. The first arrives 7 cycles after the 5th column; out_last is on the 4th output; done follows one cycle later.
- Load 25 zeros with the same stimulus -> 4 outputs of -50. cfg_bin=1 -> dout=-1. All pixels 0 with cfg_bin=1 -> dout=+1.
- OUT_W=8, all weights 1, pixels 127 -> raw sum 3175 saturates to dout=127. Pixels -128 -> dout=-128.
- Double buffer: load kernel A (all 1), start, load kernel B (all 0) during RUN -> frame 1 outputs +50. w_ready stays low once B is loaded. The next start swaps to B -> -50.
- in_valid toggling every other cycle, width=6, rows=2 -> 2 outputs per row, identical values to the full-rate run. Output gaps match the input gaps.
- Assert rstn mid-RUN, then release -> all outputs 0, busy=0, no done pulse. Weights read back as cleared: an all-ones input gives -25.
